demux_1_3_stream: RTL
=====================

// Module: demux_1_3_stream
// PURPOSE
//  Registered 1-to-3 demultiplexer with valid/ready handshakes; inverse of the 3:1 mux.
//  Routes each input word to output channel 0/1/2 selected by s.
//  Each channel holds one word until its sink takes it.
//  Counts words dropped for illegal select s=3.
//  Sits between a single producer and three independent consumers.
// PARAMETERS
//  WIDTH     3   data width of d and every y_k
//  CNT_W     8   width of drop_cnt (saturating)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  s          in   2      channel select, 0..2 legal, 3 illegal
//  d          in   WIDTH  input data
//  in_valid   in   1      producer offers {s,d}
//  in_ready   out  1      block accepts {s,d} this cycle
//  y0/y1/y2   out  WIDTH  channel data (registered)
//  v0/v1/v2   out  1      channel k holds a word
//  r0/r1/r2   in   1      sink k takes word when v_k && r_k
//  err        out  1      1-cycle pulse: illegal-select word discarded
//  drop_cnt   out  CNT_W  count of discarded words, saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): v0..v2=0, y0..y2=0, err=0, drop_cnt=0.
//   Words held at reset are lost. No partial transfer completes across reset.
//  Handshake: accept = in_valid && in_ready. Output transfer k = v_k && r_k.
//  in_ready (combinational from s, v_k, r_k; no dependence on in_valid):
//   - s==k (k<3): in_ready = !v_k || r_k.
//   - s==3: in_ready = 1 (always drained).
//  Producer rule: s and d stay stable while in_valid && !in_ready.
//  Load, s==k<3: y_k <= d, v_k <= 1 at the next edge. Latency is 1 cycle.
//  Other channels are untouched.
//  Drain: v_k <= 0 on transfer k unless channel k is loaded the same cycle.
//  Simultaneous drain+load on k: v_k stays 1, y_k takes the new d.
//   This gives back-to-back throughput of 1 word/cycle per channel.
//  While v_k && !r_k: y_k, v_k held stable (no drop, no overwrite).
//  Channels are independent. Draining k never blocks or alters j != k.
//  Illegal s==3 with accept:
//   - word discarded, no v_k changes
//   - err=1 for exactly the next cycle
//   - drop_cnt+1, holding at 2^CNT_W-1
//  err is 0 in any cycle not following an illegal accept.
//  Back-to-back illegal accepts keep err high and count each word.
//  Data path is pure pass-through, no arithmetic. y_k width = WIDTH, no extension.
//  No internal FSM beyond the per-channel full/empty bit (EMPTY->FULL on load;
//   FULL->EMPTY on drain without load; FULL->FULL on drain+load or stall).
// TESTING
//  1. Reset: rst_n=0 mid-stream with v1=1 -> immediately v0..v2=0, y=0,
//     drop_cnt=0, err=0. in_ready=1 for every s after release.
//  2. Routing: r*=1, send (s=0,d=000),(s=1,d=001),(s=2,d=010) on consecutive
//     cycles -> v0,v1,v2 each pulse 1 cycle later with y0=000,y1=001,y2=010.
//  3. Stall: r1=0, send s=1 d=101 then s=1 d=110 -> first held in y1.
//     in_ready=0 on second until r1=1, then y1=110 on the next cycle, no loss.
//  4. Drain+load: v2=1, r2=1, accept s=2 d=111 same cycle -> v2 stays 1, y2=111.
//  5. Illegal: accept s=3 three times -> err high for 3 cycles, drop_cnt=3,
//     v0..v2 unchanged. With CNT_W=2, five drops -> drop_cnt=3 (saturated).
//  6. Independence: r0=0 with v0=1 and s=2 stream -> ch2 flows at 1 word/cycle,
//     y0 stable.

Source files
------------

// File: rtl/demux_1_3_stream.sv
// Registered 1-to-3 stream demultiplexer with per-channel one-word buffers.
// Illegal select (3) words are discarded, flagged on err and counted.
module demux_1_3_stream #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    output logic             err,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [2:0]            r;
    logic [2:0]            v_q, v_d;
    logic [2:0][WIDTH-1:0] y_q, y_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept;

    assign r = {r2, r1, r0};

    // A full channel can still accept when its sink drains this cycle.
    always_comb begin
        unique case (s)
            2'd0:    in_ready = !v_q[0] || r[0];
            2'd1:    in_ready = !v_q[1] || r[1];
            2'd2:    in_ready = !v_q[2] || r[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        v_d = v_q;
        y_d = y_q;
        for (int k = 0; k < 3; k++) begin
            if (v_q[k] && r[k]) begin
                v_d[k] = 1'b0;
            end
            if (accept && s == 2'(k)) begin
                v_d[k] = 1'b1;
                y_d[k] = d;
            end
        end
        err_d = accept && (s == 2'd3);
        cnt_d = cnt_q;
        if (err_d && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            y_q   <= y_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign y0       = y_q[0];
    assign y1       = y_q[1];
    assign y2       = y_q[2];
    assign v0       = v_q[0];
    assign v1       = v_q[1];
    assign v2       = v_q[2];
    assign err      = err_q;
    assign drop_cnt = cnt_q;

endmodule
